ntt_bitrev_reorder: RTL and testbench

Output reorder stage placed directly downstream of the radix-2 SDF butterfly / Montgomery-multiplier stage. It accepts one NTT frame of N coefficients in the stage's natural (bit-reversed-index) output order and re-emits the frame in natural index order. It double-buffers (ping-pong) so one frame is written while the previous one drains. Both sides use valid/ready handshakes.

---
 rtl/ntt_bitrev_reorder_if.sv | 24 ++
 rtl/ntt_bitrev_reorder.sv | 122 ++++++++++++
 tb/tb_ntt_bitrev_reorder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bitrev_reorder_if.sv
// Coefficient stream bundle for the bit-reverse reorder stage: write side, read side and the frame error flag.
interface ntt_bitrev_reorder_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_err
  );
endinterface

// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong bit-reverse to natural order reorder of N-coefficient NTT frames; first output one cycle after the last write.
// in_ready drops only when both banks are full; registered output holds under !out_ready. Macro BITREV_FINAL_REDUCE_EN adds a mod reduction on write.
module ntt_bitrev_reorder #(
  parameter int W       = 32,
  parameter int N       = 8,
  parameter int MODULUS = 7681
) (
  input  logic               clk,
  input  logic               rst,
  ntt_bitrev_reorder_if.slave bus
);
  localparam int LOG2N = $clog2(N);
  typedef logic [LOG2N-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N - 1);

  logic [W-1:0] mem_q [2][N];

  idx_t         wr_idx_q, wr_idx_d;
  idx_t         rd_idx_q, rd_idx_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [1:0]   full_q, full_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         frame_err_q, frame_err_d;
  logic [W-1:0] wr_val;
  logic         wr_fire;
  logic         rd_load;

  function automatic idx_t bitrev(input idx_t i);
    idx_t r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
    return r;
  endfunction

`ifdef BITREV_FINAL_REDUCE_EN
  // Multiplier output lies in [0, 2*MODULUS), so one conditional subtract suffices.
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
  assign wr_val = (bus.in_data >= MOD_W) ? (bus.in_data - MOD_W) : bus.in_data;
`else
  logic unused_modulus;
  assign unused_modulus = (MODULUS != 0);
  assign wr_val         = bus.in_data;
`endif

  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;

  always_comb begin
    wr_fire     = bus.in_valid && !full_q[wr_bank_q];
    rd_load     = full_q[rd_bank_q] && (!out_valid_q || bus.out_ready);
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frame_err_d = frame_err_q;

    if (wr_fire) begin
      // Frame boundaries follow wr_idx only; a stray in_last just flags the error.
      if (bus.in_last != (wr_idx_q == LAST_IDX)) frame_err_d = 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + idx_t'(1);
      end
    end

    if (rd_load) begin
      out_data_d  = mem_q[rd_bank_q][rd_idx_q];
      out_last_d  = (rd_idx_q == LAST_IDX);
      out_valid_d = 1'b1;
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + idx_t'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][bitrev(wr_idx_q)] <= wr_val;
  end
endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Directed bench for ntt_bitrev_reorder: table-driven frames plus hand sequences for latency, stall, error flag and reset.
module tb_ntt_bitrev_reorder;
  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_bitrev_reorder_if #(.W(W)) bus ();
  ntt_bitrev_reorder #(.W(W), .N(N), .MODULUS(7681)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  typedef struct {
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;
  typedef logic [31:0] frame_t [N];

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, first_out = -1, last_out = -1, n_out = 0, not_ready = 0;
  logic        o_in_ready, o_out_valid, o_out_last, o_frame_err;
  logic [31:0] o_out_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1 ns later, score any output handshake.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    acc         = v && bus.in_ready;
    o_in_ready  = bus.in_ready;
    o_out_valid = bus.out_valid;
    o_out_data  = bus.out_data;
    o_out_last  = bus.out_last;
    o_frame_err = bus.frame_err;
    if (v && !bus.in_ready) not_ready++;
    if (bus.out_valid && ordy) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d, expected no output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
      end
    end
    cyc++;
  endtask

  function automatic int brev3(input int i);
    return {i[0], i[1], i[2]};
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] d);
`ifdef BITREV_FINAL_REDUCE_EN
    return (d >= 32'd7681) ? d - 32'd7681 : d;
`else
    return d;
`endif
  endfunction

  task automatic push_frame(input frame_t w);
    for (int a = 0; a < N; a++) exp_q.push_back('{model_store(w[brev3(a)]), (a == N - 1)});
  endtask

  task automatic write_frame(input frame_t w, input logic [N-1:0] lastmask, input logic ordy);
    logic acc;
    int   tries;
    for (int i = 0; i < N; i++) begin
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        step(1'b1, w[i], lastmask[i], ordy, acc);
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL write_timeout: word %0d accepted=%0d, required 1", i, acc);
      end
    end
  endtask

  task automatic apply_table(input vec_t v[N], input logic ordy);
    frame_t         w;
    logic [N-1:0]   lm;
    for (int i = 0; i < N; i++) begin
      w[i]  = v[i].in_data;
      lm[i] = v[i].in_last;
      exp_q.push_back('{v[i].exp_data, v[i].exp_last});
    end
    write_frame(w, lm, ordy);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      step(1'b0, 32'd0, 1'b0, 1'b1, acc);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    step(1'b0, 32'd0, 1'b0, 1'b1, acc);
  endtask

  vec_t   basic_vec [N];
  vec_t   red_vec   [N];
  frame_t fr;
  int     basic_exp [N];
  int     red_in    [N];
  int     red_out   [N];
  logic   acc;
  int     n0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    basic_exp = '{0, 4, 2, 6, 1, 5, 3, 7};
    red_in    = '{7681, 7700, 100, 1, 2, 3, 4, 5};
`ifdef BITREV_FINAL_REDUCE_EN
    red_out   = '{0, 2, 100, 4, 19, 3, 1, 5};
`else
    red_out   = '{7681, 2, 100, 4, 7700, 3, 1, 5};
`endif
    for (int i = 0; i < N; i++) begin
      basic_vec[i] = '{32'(i), (i == N - 1), 32'(basic_exp[i]), (i == N - 1)};
      red_vec[i]   = '{32'(red_in[i]), (i == N - 1), 32'(red_out[i]), (i == N - 1)};
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_last", {31'd0, bus.out_last}, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 0);
    rst = 1'b1;

    // Basic reorder and first-output latency
    apply_table(basic_vec, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("lat_valid_not_yet", {31'd0, o_out_valid}, 0);
    step(1'b0, 32'd0, 1'b0, 1'b1, acc);
    chk("lat_first_valid", {31'd0, o_out_valid}, 1);
    chk("lat_first_data", o_out_data, 0);
    drain(40);

    // Back-to-back streaming of 4 frames
    n_out = 0; first_out = -1; not_ready = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 32'(100 + f * N + i);
      push_frame(fr);
    end
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 32'(100 + f * N + i);
      write_frame(fr, 8'h80, 1'b1);
    end
    chk("stream_in_ready_stalls", not_ready, 0);
    drain(60);
    chk("stream_outputs", n_out, 32);
    chk("stream_no_bubbles", last_out - first_out, 31);

    // Backpressure: two full banks stall the writer
    n_out = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 32'(200 + f * N + i);
      push_frame(fr);
      write_frame(fr, 8'h80, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, acc);
    chk("bp_in_ready_low", {31'd0, o_in_ready}, 0);
    chk("bp_out_valid", {31'd0, o_out_valid}, 1);
    chk("bp_hold_data0", o_out_data, 200);
    step(1'b0, 32'd0, 1'b0, 1'b0, acc);
    chk("bp_hold_data1", o_out_data, 200);
    chk("bp_hold_valid", {31'd0, o_out_valid}, 1);
    n0 = 0;
    step(1'b0, 32'd0, 1'b0, 1'b1, acc);
    while (!o_in_ready && n0 < 20) begin
      n0++;
      step(1'b0, 32'd0, 1'b0, 1'b1, acc);
    end
    chk("bp_ready_rise_delay", n0, 7);
    chk("bp_ready_data_idx7", o_out_data, 207);
    drain(40);
    chk("bp_no_loss_dup", n_out, 16);

    // Misaligned in_last on the 5th word
    for (int i = 0; i < N; i++) fr[i] = 32'(300 + i);
    push_frame(fr);
    for (int i = 0; i < N; i++) begin
      step(1'b1, fr[i], (i == 4), 1'b1, acc);
      chk("mis_accept", {31'd0, acc}, 1);
      if (i == 4) chk("mis_ferr_before", {31'd0, o_frame_err}, 0);
      if (i == 5) chk("mis_ferr_set", {31'd0, o_frame_err}, 1);
    end
    drain(40);
    for (int i = 0; i < N; i++) fr[i] = 32'(350 + i);
    push_frame(fr);
    write_frame(fr, 8'h80, 1'b1);
    drain(40);
    chk("mis_ferr_sticky", {31'd0, o_frame_err}, 1);

    // Reset mid-frame with a held output and a partial frame pending
    for (int i = 0; i < N; i++) fr[i] = 32'(400 + i);
    push_frame(fr);
    write_frame(fr, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'(410 + i), 1'b0, 1'b0, acc);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, acc);
    chk("pre_rst_valid", {31'd0, o_out_valid}, 1);
    chk("pre_rst_data", o_out_data, 400);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_last", {31'd0, bus.out_last}, 0);
    chk("mid_rst_frame_err", {31'd0, bus.frame_err}, 0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    n_out = 0;
    for (int i = 0; i < N; i++) fr[i] = 32'(500 + i);
    push_frame(fr);
    write_frame(fr, 8'h80, 1'b1);
    drain(40);
    chk("post_rst_outputs", n_out, 8);

    // Final reduction vectors
    apply_table(red_vec, 1'b1);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
